// File: rtl/sram_like_axi_bridge.sv
// Bridges the CPU's instruction and data sram-like channels onto one AXI3 master port,
// issuing a single-beat transaction at a time with data-channel priority.
module sram_like_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_e;

  state_e      state_q;
  logic        owner_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic        idle;
  logic        grant;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        resp_fire;
  logic        unused_ok;

  function automatic logic [3:0] byte_strb(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    byte_strb = 4'b0001 << lsb;
      2'd1:    byte_strb = lsb[1] ? 4'b1100 : 4'b0011;
      default: byte_strb = 4'b1111;
    endcase
  endfunction

  // Grants are masked during reset so every handshake output reads 0 while resetn is low.
  assign idle         = (state_q == IDLE) && resetn;
  assign data_addr_ok = idle && data_req;
  assign inst_addr_ok = idle && inst_req && !data_req;
  assign grant        = idle && (inst_req || data_req);

  assign sel_wr    = data_req ? data_wr    : inst_wr;
  assign sel_size  = data_req ? data_size  : inst_size;
  assign sel_addr  = data_req ? data_addr  : inst_addr;
  assign sel_wdata = data_req ? data_wdata : inst_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q <= data_req;
            size_q  <= sel_size;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wstrb_q <= byte_strb(sel_size, sel_addr[1:0]);
            state_q <= sel_wr ? WR_ADDR : RD_ADDR;
          end
        end
        RD_ADDR: if (arready) state_q <= RD_DATA;
        RD_DATA: if (rvalid) state_q <= IDLE;
        WR_ADDR: begin
          // AW and W complete independently; leave once both have been seen.
          if ((aw_done_q || awready) && (w_done_q || wready)) begin
            state_q   <= WR_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_q || awready;
            w_done_q  <= w_done_q || wready;
          end
        end
        WR_RESP: if (bvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arid    = owner_q ? DATA_ID : INST_ID;
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);

  assign awid    = owner_q ? DATA_ID : INST_ID;
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_q};
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awvalid = (state_q == WR_ADDR) && !aw_done_q;
  assign wvalid  = (state_q == WR_ADDR) && !w_done_q;
  assign wlast   = wvalid;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = (state_q == WR_RESP);

  assign resp_fire    = ((state_q == RD_DATA) && rvalid) || ((state_q == WR_RESP) && bvalid);
  assign inst_data_ok = resp_fire && !owner_q;
  assign data_data_ok = resp_fire && owner_q;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  // Only one transaction is ever in flight, so the read ID and last flag carry no information.
  assign unused_ok = ^{rid, rlast};

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Scoreboard bench: grants push expected AXI transfers, a slave model checks them and
// queues expected sram-like responses, and a monitor pops and compares on each response.
module tb_sram_like_axi_bridge;

  localparam logic [3:0] INST_ID_T = 4'd0;
  localparam logic [3:0] DATA_ID_T = 4'd1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, arlen, rid, awid, awlen, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_like_axi_bridge #(.INST_ID(INST_ID_T), .DATA_ID(DATA_ID_T)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          ch;      // 1 = data channel
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          ch;
    bit          rd;
    logic [31:0] data;
  } rsp_t;

  req_t exp_axi[$];
  rsp_t exp_rsp[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte lanes touched by an access of 2**size bytes, aligned down to its natural boundary.
  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
    int n;
    int base;
    logic [3:0] s;
    n    = (sz >= 2'd2) ? 4 : (1 << sz);
    base = (int'(a[1:0]) / n) * n;
    s    = 4'b0000;
    for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + n);
    return s;
  endfunction

  // ---------------- monitor: grants and responses ----------------
  bit   busy    = 1'b0;
  bit   lat_chk = 1'b0;
  int   cyc     = 0;
  int   gcyc    = 0;
  bit   m_resp;
  rsp_t m_e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        busy = 1'b0;
        exp_axi.delete();
        exp_rsp.delete();
      end else begin
        m_resp = (rvalid && rready) || (bvalid && bready);
        if (busy) begin
          if (inst_req || data_req) chk("addr_ok_while_busy", {inst_addr_ok, data_addr_ok}, 0);
        end else if (inst_req || data_req) begin
          chk("data_addr_ok", data_addr_ok, data_req);
          chk("inst_addr_ok", inst_addr_ok, inst_req && !data_req);
        end
        if (m_resp) begin
          chk("rsp_queue_nonempty", exp_rsp.size() != 0, 1);
          if (exp_rsp.size() != 0) begin
            m_e = exp_rsp.pop_front();
            chk("inst_data_ok", inst_data_ok, !m_e.ch);
            chk("data_data_ok", data_data_ok, m_e.ch);
            if (m_e.rd) chk("owner_rdata", m_e.ch ? data_rdata : inst_rdata, m_e.data);
            if (lat_chk) chk("min_latency", cyc - gcyc, 2);
          end
          busy = 1'b0;
        end else if (inst_data_ok || data_data_ok) begin
          chk("spurious_data_ok", {inst_data_ok, data_data_ok}, 0);
        end
        if (data_req && data_addr_ok) begin
          exp_axi.push_back('{ch: 1'b1, wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata});
          busy = 1'b1;
          gcyc = cyc;
        end else if (inst_req && inst_addr_ok) begin
          exp_axi.push_back('{ch: 1'b0, wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata});
          busy = 1'b1;
          gcyc = cyc;
        end
      end
    end
  end

  // ---------------- AXI slave model ----------------
  bit          fast = 1'b1, r_hold = 1'b0, rdat_force_v = 1'b0;
  logic [31:0] rdat_force = 32'd0;
  int          ar_block = 0, aw_block = 0;
  req_t        cur;
  bit          cur_v = 0, ar_got = 0, aw_got = 0, w_got = 0, r_fire = 0, b_fire = 0;
  bit          ar_wait = 0, aw_wait = 0;
  logic [31:0] ar_prev, aw_prev;
  int          r_cnt = 0, b_cnt = 0;

  task automatic take();
    if (!cur_v) begin
      chk("axi_queue_nonempty", exp_axi.size() != 0, 1);
      if (exp_axi.size() != 0) begin
        cur   = exp_axi.pop_front();
        cur_v = 1'b1;
      end
    end
  endtask

  initial begin
    arready = 0; rvalid = 0; rdata = 0; rid = 0; rlast = 1; awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(negedge clk);
      r_fire = 0;
      b_fire = 0;
      if (!resetn) begin
        cur_v = 0; ar_got = 0; aw_got = 0; w_got = 0; ar_wait = 0; aw_wait = 0;
      end else begin
        if (ar_wait) begin
          chk("arvalid_held", arvalid, 1);
          chk("araddr_stable", araddr, ar_prev);
        end
        if (aw_wait) begin
          chk("awvalid_held", awvalid, 1);
          chk("awaddr_stable", awaddr, aw_prev);
        end
        if (cur_v && cur.wr && w_got && !aw_got) chk("wvalid_dropped", wvalid, 0);
        if (cur_v && cur.wr && !(aw_got && w_got)) chk("bready_early", bready, 0);
        ar_wait = arvalid && !arready;
        ar_prev = araddr;
        aw_wait = awvalid && !awready;
        aw_prev = awaddr;
        if (arvalid && ar_block > 0) ar_block--;
        if (awvalid && aw_block > 0) aw_block--;
        if (arvalid && arready) begin
          chk("ar_single_outstanding", cur_v, 0);
          take();
          chk("arid", arid, cur.ch ? DATA_ID_T : INST_ID_T);
          chk("araddr", araddr, cur.addr);
          chk("arsize", arsize, {1'b0, cur.size});
          chk("ar_for_read", cur.wr, 0);
          ar_got = 1;
          r_cnt  = fast ? 0 : $urandom_range(0, 3);
        end
        if (awvalid && awready) begin
          chk("aw_once", aw_got, 0);
          take();
          chk("awid", awid, cur.ch ? DATA_ID_T : INST_ID_T);
          chk("awaddr", awaddr, cur.addr);
          chk("awsize", awsize, {1'b0, cur.size});
          chk("aw_for_write", cur.wr, 1);
          aw_got = 1;
          b_cnt  = fast ? 0 : $urandom_range(0, 3);
        end
        if (wvalid && wready) begin
          chk("w_once", w_got, 0);
          take();
          chk("wdata", wdata, cur.wdata);
          chk("wstrb", wstrb, exp_strb(cur.size, cur.addr));
          chk("wlast", wlast, 1);
          w_got = 1;
          b_cnt = fast ? 0 : $urandom_range(0, 3);
        end
        if (rvalid && rready) begin
          r_fire = 1; cur_v = 0; ar_got = 0;
        end
        if (bvalid && bready) begin
          b_fire = 1; cur_v = 0; aw_got = 0; w_got = 0;
        end
      end
      @(posedge clk);
      #1;
      if (!resetn) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      end else begin
        arready = (ar_block == 0) && (fast || $urandom_range(0, 2) != 0);
        awready = (aw_block == 0) && (fast || $urandom_range(0, 2) != 0);
        wready  = fast || $urandom_range(0, 2) != 0;
        if (r_fire) rvalid = 0;
        if (b_fire) bvalid = 0;
        if (ar_got && !rvalid && !r_hold) begin
          if (r_cnt > 0) r_cnt--;
          else begin
            rvalid = 1;
            rdata  = rdat_force_v ? rdat_force : $urandom;
            exp_rsp.push_back('{ch: cur.ch, rd: 1'b1, data: rdata});
          end
        end
        if (aw_got && w_got && !bvalid) begin
          if (b_cnt > 0) b_cnt--;
          else begin
            bvalid = 1;
            exp_rsp.push_back('{ch: cur.ch, rd: 1'b0, data: 32'd0});
          end
        end
      end
    end
  end

  // ---------------- requester ----------------
  task automatic do_req(input bit ui, input bit ud, input logic wi, input logic wd,
                        input logic [1:0] si, input logic [1:0] sd,
                        input logic [31:0] ai, input logic [31:0] ad,
                        input logic [31:0] wdi, input logic [31:0] wdd);
    bit gi, gd;
    int guard;
    @(posedge clk);
    #1;
    inst_req = ui; inst_wr = wi; inst_size = si; inst_addr = ai; inst_wdata = wdi;
    data_req = ud; data_wr = wd; data_size = sd; data_addr = ad; data_wdata = wdd;
    guard = 0;
    while ((inst_req || data_req) && guard < 300) begin
      @(negedge clk);
      guard++;
      gi = inst_req && inst_addr_ok;
      gd = data_req && data_addr_ok;
      @(posedge clk);
      #1;
      if (gi) inst_req = 0;
      if (gd) data_req = 0;
    end
    chk("grant_within_bound", inst_req || data_req, 0);
    inst_req = 0;
    data_req = 0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      #2;
      g++;
    end while ((busy || exp_axi.size() != 0 || exp_rsp.size() != 0) && g < 400);
    chk("idle_within_bound", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_ready"}, {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk({tag, "_ok"}, {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wstrb"}, wstrb, 0);
  endtask

  initial begin
    int g;
    resetn = 0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    inst_req = 1;
    data_req = 1;
    #1;
    check_reset_outputs("por");
    chk("len_burst_consts", {arlen, awlen, arburst, awburst}, {4'd0, 4'd0, 2'b01, 2'b01});
    inst_req = 0;
    data_req = 0;
    @(posedge clk);
    #1;
    resetn = 1;

    // Zero-wait instruction fetch
    fast = 1; lat_chk = 1; rdat_force_v = 1; rdat_force = 32'h3C1D0001;
    do_req(1, 0, 0, 0, 2'd2, 2'd0, 32'h1FC00000, 0, 0, 0);
    wait_idle();
    rdat_force_v = 0;

    // Byte store to the top lane
    do_req(0, 1, 0, 1, 2'd0, 2'd0, 0, 32'h80000003, 0, 32'h000000AB);
    wait_idle();

    // W completes well before AW
    lat_chk = 0; aw_block = 3;
    do_req(0, 1, 0, 1, 2'd0, 2'd2, 0, 32'h80000010, 0, 32'h12345678);
    wait_idle();

    // Simultaneous requests: data first, instruction right after
    do_req(1, 1, 0, 0, 2'd2, 2'd2, 32'h1FC00004, 32'h80000020, 0, 0);
    wait_idle();

    // Read-address backpressure with an instruction request waiting
    ar_block = 5;
    do_req(1, 1, 0, 0, 2'd2, 2'd1, 32'h1FC00008, 32'h80000042, 0, 0);
    wait_idle();

    // Randomised traffic against a randomly stalling slave
    fast = 0;
    for (int n = 0; n < 80; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(mode != 1, mode != 0, 1'($urandom), 1'($urandom),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, $urandom);
    end
    wait_idle();

    // Reset while the read data phase is pending
    fast = 1; r_hold = 1;
    do_req(1, 0, 0, 0, 2'd2, 2'd0, 32'h00001000, 0, 0, 0);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rready && g < 50);
    chk("reached_rd_data", rready, 1);
    @(posedge clk);
    #1;
    inst_req = 1; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h1FC00010;
    resetn = 0;
    #1;
    check_reset_outputs("mid_rd");
    r_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    @(negedge clk);
    chk("inst_addr_ok_after_reset", inst_addr_ok, 1);
    @(posedge clk);
    #1;
    inst_req = 0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    total++;
    bad++;
    $display("FAIL watchdog: time limit reached, busy=%0d", busy);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
